// File: rtl/door_access_ctrl.sv
// -----------------------------------------------------------------------------
// door_access_ctrl
//
// Keypad door-access controller. A person at the door arms the keypad, opens
// an entry with the start/clear key, types the BCD access code and presses
// enter. A correct code unlocks the servo until the door has opened and closed
// again (or until nobody opens it in time). Too many consecutive wrong codes
// raise the alarm. The inside exit button unlocks the door directly, except
// while the alarm is sounding.
//
// Optional feature (macro DOOR_AJAR_ALARM_EN): when defined, a door left open
// longer than OPEN_TO cycles sounds the buzzer and shows the "ajar" message
// until it is closed. When undefined, an open door never buzzes.
//
// Ports
//   clk        in   1  single clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   presence   in   1  1 = person detected at the door
//   key_valid  in   1  one-cycle strobe qualifying key_code
//   key_code   in   4  0-9 digit, 4'hA start/clear, 4'hB enter, others ignored
//   inside_btn in   1  1 = exit request from inside
//   reed       in   1  door sensor, 1 = closed, 0 = open
//   unlock     out  1  1 = servo commanded open
//   buzz       out  1  alarm buzzer drive
//   msg        out  3  0 idle, 1 armed, 2 entry, 3 open, 4 alarm, 5 ajar
//   digit_cnt  out  4  digits currently buffered
//   fail_cnt   out  3  consecutive failed entries
// -----------------------------------------------------------------------------
module door_access_ctrl #(
   parameter int unsigned CODE_DIGITS = 4,
   parameter logic [31:0] CODE        = 32'h0000_4693,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned ENTRY_TO    = 250_000_000,
   parameter int unsigned OPEN_TO     = 250_000_000,
   parameter int unsigned ALARM_CYC   = 500_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       presence,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       inside_btn,
   input  logic       reed,
   output logic       unlock,
   output logic       buzz,
   output logic [2:0] msg,
   output logic [3:0] digit_cnt,
   output logic [2:0] fail_cnt
);

   localparam int unsigned     BW        = 4 * CODE_DIGITS;
   localparam logic [BW-1:0]   CODE_BCD  = CODE[BW-1:0];
   localparam logic [3:0]      DIGITS    = 4'(CODE_DIGITS);
   localparam logic [2:0]      TRIES     = 3'(MAX_TRIES);
   // The timer reads 0 during the first cycle in a state, so "N cycles have
   // elapsed" is true while it holds N-1.
   localparam logic [31:0]     ENTRY_LIM = 32'(ENTRY_TO - 1);
   localparam logic [31:0]     OPEN_LIM  = 32'(OPEN_TO - 1);
   localparam logic [31:0]     ALARM_LIM = 32'(ALARM_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_ENTRY, S_GRANTED, S_OPEN, S_ALARM
   } state_t;

   state_t         state, state_next;
   logic [BW-1:0]  code_buf, code_buf_next;
   logic [3:0]     cnt_next;
   logic [2:0]     fails_next;
   logic [31:0]    timer, timer_next;
   logic           key_activity;
   logic           unlock_next, buzz_next;
   logic [2:0]     msg_next;
   logic           ajar;

   wire is_digit = key_valid && (key_code <= 4'd9);
   wire is_clear = key_valid && (key_code == 4'hA);
   wire is_enter = key_valid && (key_code == 4'hB);

`ifdef DOOR_AJAR_ALARM_EN
   // Door still open after the allowed time; reed=0 keeps the FSM in OPEN.
   assign ajar = (state == S_OPEN) && !reed && (timer >= OPEN_LIM);
`else
   assign ajar = 1'b0;
`endif

   // NOTE: every signal written here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next    = state;
      code_buf_next = code_buf;
      cnt_next      = digit_cnt;
      fails_next    = fail_cnt;
      key_activity  = 1'b0;

      case (state)
         S_IDLE: begin
            if (inside_btn)    state_next = S_GRANTED;
            else if (presence) state_next = S_ARMED;
         end
         // The exit button is checked before presence loss: someone inside
         // asking to leave must never be ignored.
         S_ARMED: begin
            if (inside_btn)     state_next = S_GRANTED;
            else if (!presence) state_next = S_IDLE;
            else if (is_clear)  state_next = S_ENTRY;
         end
         S_ENTRY: begin
            if (inside_btn)     state_next = S_GRANTED;
            else if (!presence) state_next = S_IDLE;
            else if (key_valid) begin
               key_activity = 1'b1;
               if (is_digit) begin
                  if (digit_cnt < DIGITS) begin
                     code_buf_next = BW'({code_buf, key_code});
                     cnt_next      = digit_cnt + 4'd1;
                  end
               end else if (is_clear) begin
                  code_buf_next = '0;
                  cnt_next      = '0;
               end else if (is_enter) begin
                  if ((digit_cnt == DIGITS) && (code_buf == CODE_BCD)) begin
                     state_next = S_GRANTED;
                     fails_next = '0;
                  end else begin
                     fails_next    = fail_cnt + 3'd1;
                     code_buf_next = '0;
                     cnt_next      = '0;
                     if (fails_next == TRIES) state_next = S_ALARM;
                  end
               end
            end else if (timer >= ENTRY_LIM) begin
               state_next = S_ARMED;
            end
         end
         S_GRANTED: begin
            if (!reed)                  state_next = S_OPEN;
            else if (timer >= OPEN_LIM) state_next = S_IDLE;
         end
         S_OPEN: begin
            if (reed) state_next = S_IDLE;
         end
         S_ALARM: begin
            if ((timer >= ALARM_LIM) && !presence) begin
               state_next = S_IDLE;
               fails_next = '0;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // The buffer only lives inside ENTRY; any exit discards it.
      if (state_next != S_ENTRY) begin
         code_buf_next = '0;
         cnt_next      = '0;
      end

      // Restart on state entry and on keypad activity; saturate at all-ones.
      if ((state_next != state) || key_activity) timer_next = '0;
      else if (timer != '1)                      timer_next = timer + 32'd1;
      else                                       timer_next = timer;

      unlock_next = (state_next == S_GRANTED) || (state_next == S_OPEN);
      buzz_next   = (state_next == S_ALARM) || ajar;
      case (state_next)
         S_IDLE:    msg_next = 3'd0;
         S_ARMED:   msg_next = 3'd1;
         S_ENTRY:   msg_next = 3'd2;
         S_GRANTED: msg_next = 3'd3;
         S_OPEN:    msg_next = ajar ? 3'd5 : 3'd3;
         S_ALARM:   msg_next = 3'd4;
         default:   msg_next = 3'd0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         code_buf  <= '0;
         digit_cnt <= '0;
         fail_cnt  <= '0;
         timer     <= '0;
         unlock    <= 1'b0;
         buzz      <= 1'b0;
         msg       <= 3'd0;
      end else begin
         state     <= state_next;
         code_buf  <= code_buf_next;
         digit_cnt <= cnt_next;
         fail_cnt  <= fails_next;
         timer     <= timer_next;
         unlock    <= unlock_next;
         buzz      <= buzz_next;
         msg       <= msg_next;
      end
   end

endmodule

// File: tb/tb_door_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_door_access_ctrl
//
// Self-checking bench for door_access_ctrl with a short-timeout configuration.
// A vector table covers the main keypad flows, hand-written sequences cover
// the timed corners and the asynchronous reset, and a random run is compared
// cycle by cycle against a behavioural model of the access rules.
// -----------------------------------------------------------------------------
module tb_door_access_ctrl;

   localparam int          N         = 4;
   localparam logic [31:0] CODE      = 32'h0000_4693;
   localparam int          MAX_TRIES = 3;
   localparam int          ENTRY_TO  = 100;
   localparam int          OPEN_TO   = 50;
   localparam int          ALARM_CYC = 20;
`ifdef DOOR_AJAR_ALARM_EN
   localparam bit          AJAR      = 1'b1;
`else
   localparam bit          AJAR      = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       presence = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       inside_btn = 1'b0;
   logic       reed = 1'b1;
   logic       unlock, buzz;
   logic [2:0] msg;
   logic [3:0] digit_cnt;
   logic [2:0] fail_cnt;

   int errors = 0;
   int checks = 0;

   door_access_ctrl #(
      .CODE_DIGITS(N), .CODE(CODE), .MAX_TRIES(MAX_TRIES),
      .ENTRY_TO(ENTRY_TO), .OPEN_TO(OPEN_TO), .ALARM_CYC(ALARM_CYC)
   ) dut (
      .clk(clk), .reset(reset), .presence(presence), .key_valid(key_valid),
      .key_code(key_code), .inside_btn(inside_btn), .reed(reed),
      .unlock(unlock), .buzz(buzz), .msg(msg), .digit_cnt(digit_cnt),
      .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [11:0] pk(input logic u, input logic b, input logic [2:0] m,
                                      input logic [3:0] d, input logic [2:0] f);
      return {u, b, m, d, f};
   endfunction

   task automatic check(input string name, input logic [11:0] exp);
      logic [11:0] act;
      act = {unlock, buzz, msg, digit_cnt, fail_cnt};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got unlock=%0b buzz=%0b msg=%0d digit_cnt=%0d fail_cnt=%0d, want unlock=%0b buzz=%0b msg=%0d digit_cnt=%0d fail_cnt=%0d",
                  name, act[11], act[10], act[9:7], act[6:3], act[2:0],
                  exp[11], exp[10], exp[9:7], exp[6:3], exp[2:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      key_valid = 1'b1;
      key_code  = k;
      tick();
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      presence   = 1'b0;
      key_valid  = 1'b0;
      key_code   = 4'd0;
      inside_btn = 1'b0;
      reed       = 1'b1;
      tick();
      check("reset_state", pk(0, 0, 0, 0, 0));
      reset = 1'b1;
   endtask

   // ---------------- behavioural model of the access rules ----------------
   localparam int M_IDLE = 0, M_ARMED = 1, M_ENTRY = 2, M_GRANTED = 3, M_OPEN = 4, M_ALARM = 5;
   int m_mode;
   int m_q[$];     // digits typed so far, first typed at index 0
   int m_fails;
   int m_quiet;    // whole cycles spent in this mode since entry or last key

   function automatic int code_digit(input int i);
      return int'((CODE >> (4 * (N - 1 - i))) & 32'hF);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_q.delete(); m_fails = 0; m_quiet = 0;
   endtask

   task automatic model_step(input bit p, input bit kv, input int kc, input bit ib, input bit rd);
      int nm;
      bit restart, match;
      nm = m_mode;
      restart = 1'b0;
      case (m_mode)
         M_IDLE:  if (ib) nm = M_GRANTED; else if (p) nm = M_ARMED;
         M_ARMED: if (ib) nm = M_GRANTED; else if (!p) nm = M_IDLE;
                  else if (kv && kc == 10) nm = M_ENTRY;
         M_ENTRY: begin
            if (ib) nm = M_GRANTED;
            else if (!p) nm = M_IDLE;
            else if (kv) begin
               restart = 1'b1;
               if (kc <= 9) begin
                  if (m_q.size() < N) m_q.push_back(kc);
               end else if (kc == 10) begin
                  m_q.delete();
               end else if (kc == 11) begin
                  match = (m_q.size() == N);
                  for (int i = 0; i < m_q.size(); i++)
                     if (m_q[i] != code_digit(i)) match = 1'b0;
                  if (match) begin
                     nm = M_GRANTED;
                     m_fails = 0;
                  end else begin
                     m_fails++;
                     m_q.delete();
                     if (m_fails == MAX_TRIES) nm = M_ALARM;
                  end
               end
            end else if (m_quiet + 1 >= ENTRY_TO) nm = M_ARMED;
         end
         M_GRANTED: if (!rd) nm = M_OPEN; else if (m_quiet + 1 >= OPEN_TO) nm = M_IDLE;
         M_OPEN:    if (rd) nm = M_IDLE;
         M_ALARM:   if (m_quiet + 1 >= ALARM_CYC && !p) begin nm = M_IDLE; m_fails = 0; end
         default:   nm = M_IDLE;
      endcase
      if (nm != M_ENTRY) m_q.delete();
      m_quiet = (nm != m_mode || restart) ? 0 : m_quiet + 1;
      m_mode = nm;
   endtask

   function automatic logic [11:0] model_out();
      bit u, b, aj;
      logic [2:0] m;
      aj = AJAR && (m_mode == M_OPEN) && (m_quiet >= OPEN_TO);
      u  = (m_mode == M_GRANTED) || (m_mode == M_OPEN);
      b  = (m_mode == M_ALARM) || aj;
      case (m_mode)
         M_IDLE:  m = 3'd0;
         M_ARMED: m = 3'd1;
         M_ENTRY: m = 3'd2;
         M_ALARM: m = 3'd4;
         default: m = aj ? 3'd5 : 3'd3;
      endcase
      return pk(u, b, m, 4'(m_q.size()), 3'(m_fails));
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic       p, kv;
      logic [3:0] kc;
      logic       ib, rd;
      logic       u, b;
      logic [2:0] m;
      logic [3:0] d;
      logic [2:0] f;
   } vec_t;

   vec_t vecs[22];

   initial begin
      logic [11:0] exp;
      bit p, kv, ib, rd;
      int kc, r;

      //            p kv kc    ib rd   u b m d f
      vecs[0]  = '{1, 0, 4'h0, 0, 1,  0, 0, 1, 0, 0};  // arm
      vecs[1]  = '{1, 1, 4'hA, 0, 1,  0, 0, 2, 0, 0};  // start entry
      vecs[2]  = '{1, 1, 4'h4, 0, 1,  0, 0, 2, 1, 0};
      vecs[3]  = '{1, 1, 4'h6, 0, 1,  0, 0, 2, 2, 0};
      vecs[4]  = '{1, 1, 4'h9, 0, 1,  0, 0, 2, 3, 0};
      vecs[5]  = '{1, 1, 4'h3, 0, 1,  0, 0, 2, 4, 0};
      vecs[6]  = '{1, 1, 4'h7, 0, 1,  0, 0, 2, 4, 0};  // extra digit dropped
      vecs[7]  = '{1, 1, 4'hB, 0, 1,  1, 0, 3, 0, 0};  // granted
      vecs[8]  = '{1, 0, 4'h0, 0, 0,  1, 0, 3, 0, 0};  // door opens
      vecs[9]  = '{1, 0, 4'h0, 0, 0,  1, 0, 3, 0, 0};
      vecs[10] = '{1, 0, 4'h0, 0, 1,  0, 0, 0, 0, 0};  // closed -> relocked
      vecs[11] = '{0, 0, 4'h0, 0, 1,  0, 0, 0, 0, 0};
      vecs[12] = '{1, 0, 4'h0, 0, 1,  0, 0, 1, 0, 0};
      vecs[13] = '{1, 1, 4'h5, 0, 1,  0, 0, 1, 0, 0};  // digit ignored when armed
      vecs[14] = '{1, 1, 4'hA, 0, 1,  0, 0, 2, 0, 0};
      vecs[15] = '{1, 1, 4'h1, 0, 1,  0, 0, 2, 1, 0};
      vecs[16] = '{1, 1, 4'hB, 0, 1,  0, 0, 2, 0, 1};  // short code fails
      vecs[17] = '{1, 1, 4'hC, 0, 1,  0, 0, 2, 0, 1};  // unknown key ignored
      vecs[18] = '{1, 1, 4'h5, 0, 1,  0, 0, 2, 1, 1};
      vecs[19] = '{1, 1, 4'hA, 0, 1,  0, 0, 2, 0, 1};  // clear is not a failure
      vecs[20] = '{1, 1, 4'h5, 1, 1,  1, 0, 3, 0, 1};  // exit button beats key
      vecs[21] = '{0, 0, 4'h0, 0, 1,  1, 0, 3, 0, 1};

      do_reset();
      for (int i = 0; i < $size(vecs); i++) begin
         presence = vecs[i].p; key_valid = vecs[i].kv; key_code = vecs[i].kc;
         inside_btn = vecs[i].ib; reed = vecs[i].rd;
         tick();
         check($sformatf("vec%0d", i), pk(vecs[i].u, vecs[i].b, vecs[i].m, vecs[i].d, vecs[i].f));
      end
      key_valid = 1'b0; inside_btn = 1'b0;

      // Three wrong entries raise the alarm; exit needs elapsed time and no presence.
      do_reset();
      presence = 1'b1;
      tick();
      for (int e = 0; e < 3; e++) begin
         press(4'hA); press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);
         if (e < 2) check($sformatf("wrong_entry%0d", e), pk(0, 0, 2, 0, 3'(e + 1)));
         else       check("alarm_entry", pk(0, 1, 4, 0, 3));
      end
      for (int k = 1; k <= ALARM_CYC; k++) begin
         presence   = (k < 5);
         inside_btn = (k == 3);
         tick();
         if (k < ALARM_CYC) check($sformatf("alarm_hold%0d", k), pk(0, 1, 4, 0, 3));
         else               check("alarm_exit", pk(0, 0, 0, 0, 0));
      end
      inside_btn = 1'b0;

      // Presence lost mid-entry keeps the failure count.
      do_reset();
      presence = 1'b1;
      tick();
      press(4'hA);
      for (int e = 0; e < 2; e++) begin
         press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);
      end
      press(4'h7);
      check("two_fails_partial", pk(0, 0, 2, 1, 2));
      presence = 1'b0;
      tick();
      check("presence_drop", pk(0, 0, 0, 0, 2));
      presence = 1'b1;
      tick();
      check("rearm_keeps_fails", pk(0, 0, 1, 0, 2));
      press(4'hA); press(4'h9); press(4'hB);
      check("third_fail_alarm", pk(0, 1, 4, 0, 3));

      // Entry timeout returns to ARMED without a failure.
      do_reset();
      presence = 1'b1;
      tick();
      press(4'hA); press(4'h4); press(4'h6);
      for (int k = 1; k <= ENTRY_TO; k++) begin
         tick();
         if (k == ENTRY_TO - 1) check("entry_before_to", pk(0, 0, 2, 2, 0));
         if (k == ENTRY_TO)     check("entry_timeout", pk(0, 0, 1, 0, 0));
      end

      // Unlock with no door movement relocks; then door held open.
      do_reset();
      presence = 1'b1; inside_btn = 1'b1;
      tick();
      check("idle_btn_wins", pk(1, 0, 3, 0, 0));
      presence = 1'b0; inside_btn = 1'b0;
      for (int k = 1; k <= OPEN_TO; k++) begin
         tick();
         if (k == OPEN_TO - 1) check("granted_before_to", pk(1, 0, 3, 0, 0));
         if (k == OPEN_TO)     check("granted_timeout", pk(0, 0, 0, 0, 0));
      end
      inside_btn = 1'b1;
      tick();
      inside_btn = 1'b0; reed = 1'b0;
      tick();
      check("door_open", pk(1, 0, 3, 0, 0));
      for (int k = 1; k <= 60; k++) begin
         tick();
         if (k == 49) check("open_cycle50", pk(1, 0, 3, 0, 0));
         if (k == 50) check("open_cycle51", pk(1, AJAR, AJAR ? 3'd5 : 3'd3, 0, 0));
         if (k == 60) check("open_cycle61", pk(1, AJAR, AJAR ? 3'd5 : 3'd3, 0, 0));
      end
      reed = 1'b1;
      tick();
      check("door_closed", pk(0, 0, 0, 0, 0));

      // Asynchronous reset while the door is open.
      inside_btn = 1'b1;
      tick();
      inside_btn = 1'b0; reed = 1'b0;
      tick();
      check("open_before_reset", pk(1, 0, 3, 0, 0));
      #2 reset = 1'b0;
      #1 check("async_reset", pk(0, 0, 0, 0, 0));
      tick();
      reset = 1'b1;

      // Random run against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         p  = ($urandom_range(0, 99) < 97);
         kv = ((c % 500) >= 130) && ($urandom_range(0, 99) < 35);
         r  = $urandom_range(0, 9);
         if (r < 5)       kc = code_digit(m_q.size() < N ? m_q.size() : 0);
         else if (r == 5) kc = 10;
         else if (r < 8)  kc = 11;
         else             kc = $urandom_range(0, 15);
         ib = ($urandom_range(0, 199) == 0);
         rd = ($urandom_range(0, 9) > 2);
         presence = p; key_valid = kv; key_code = 4'(kc); inside_btn = ib; reed = rd;
         tick();
         model_step(p, kv, kc, ib, rd);
         exp = model_out();
         check($sformatf("rand_c%0d", c), exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
